// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and constants for the data memory arbiter
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       gnt_valid,
  output logic       gnt_owner
);

  // req[0] is the CPU and req[1] the DMA, matching the owner encoding
  always_comb begin
    gnt_valid = |req;
    gnt_owner = OWNER_CPU;
    if (req == 2'b11) begin
      gnt_owner = ~last_owner;
    end else if (req[1]) begin
      gnt_owner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data memory between the CPU MEM stage and the DMA loader
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              owner
);

  arb_state_t           state;
  logic                 last_owner;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 gnt_valid;
  logic                 gnt_owner;

  rr_arb2 u_rr_arb2 (
    .req        ({dma_req, cpu_req}),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWNER_DMA;
      owner      <= OWNER_CPU;
      lat_cnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_done   <= 1'b0;
      dma_done   <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            owner      <= gnt_owner;
            last_owner <= gnt_owner;
            if (gnt_owner == OWNER_DMA) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end

        ISSUE: begin
          if (mem_we) begin
            state <= DONE;
            if (owner == OWNER_DMA) dma_done <= 1'b1;
            else                    cpu_done <= 1'b1;
          end else begin
            lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end

        // Counter hits zero in the last cycle mem_rdata is guaranteed valid
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= DONE;
            if (owner == OWNER_DMA) begin
              dma_rdata <= mem_rdata;
              dma_done  <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_done  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        // Requester still shows its finished request here, so nothing is granted
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the pipeline's MEM stage (CPU port) and a DMA/host loader port that preloads and drains data memory (DMA port).
- Sits between the pipeline's memory-access stage and the memory controller.
- Multi-cycle FSM with round-robin arbitration.
- Drives a stall back to the pipeline until the CPU access completes.

Parameters:
- ADDR_W, 16: word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 2: cycles from the mem_en cycle to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered CPU read data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  pipeline stall, equal to cpu_req & ~cpu_done.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done: same as the CPU equivalents, for the DMA port.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  current or last grantee: 0 = CPU, 1 = DMA.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata, cpu_done, dma_done, busy = 0.
  - cpu_rdata, dma_rdata = 0.
  - last_owner = DMA, so the first tie goes to the CPU; owner = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples requests at the clock edge.
  - If exactly one requester is active, grant it.
  - If both are active, grant the one that is not last_owner.
  - On a grant: latch we/addr/wdata into the mem_* output registers, set owner and last_owner, go to ISSUE.
  - With no request, stay in IDLE and keep mem_en = 0.
- ISSUE:
  - mem_en = 1 for exactly this cycle.
  - Write: go to DONE.
  - Read: load the latency counter with MEM_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture mem_rdata into the grantee's rdata register and go to DONE.
  - mem_en = 0 throughout WAIT.
- DONE:
  - Pulse the grantee's done for one cycle; the other port's done stays 0.
  - Requests are ignored in this cycle, because the requester still shows its old request.
  - Go to IDLE.
- Latency, with the request first sampled at edge t:
  - mem_en high in cycle t+1.
  - Write: done in cycle t+2.
  - Read: rdata valid and done in cycle t+2+MEM_LAT.
- Minimum spacing between back-to-back grants is 3 cycles for writes and 3+MEM_LAT cycles for reads.
- Read data hold rules:
  - Each rdata register holds its value until that port's next read completes.
  - Writes and the other port's transactions never alter it.
- A requester dropping req mid-transaction is a protocol violation. The transaction still completes and done still pulses; the block does not abort.
- cpu_stall is combinational and may be high in the reset cycle if cpu_req is high.
- If reset asserts mid-transaction (ISSUE/WAIT/DONE), the transaction is abandoned: no done pulse, mem_en drops immediately. After reset releases, a still-asserted request is re-arbitrated from IDLE.
- owner keeps its last value in IDLE.

Decomposition:
- Package data_mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - constants OWNER_CPU = 1'b0 and OWNER_DMA = 1'b1.
  - latency counter width LAT_CNT_W = 4.
- Sub-module rr_arb2: 2-way round-robin grant from req[1:0] and last_owner. Combinational, instantiated once; the last_owner register stays in the parent.

Test Plan (MEM_LAT = 2):
1. Reset: hold rst low 3 cycles with cpu_req = 1 -> all mem_* = 0, both done = 0, busy = 0, owner = 0, cpu_stall = 1. After release, the CPU is granted on the first edge.
2. CPU read, addr 0x0010, memory returns 0xDEADBEEF -> mem_en only at t+1 with mem_addr = 0x0010, mem_we = 0; cpu_done at t+4; cpu_rdata = 0xDEADBEEF; cpu_stall high t..t+3, low at t+4.
3. DMA write, addr 0x0100, data 0x12345678 -> mem_en = mem_we = 1 only at t+1 with matching addr/data; dma_done at t+2; cpu_rdata unchanged.
4. Both request simultaneously from reset, each re-requesting after done -> grant order CPU, DMA, CPU, DMA. owner toggles accordingly; no cycle has both done signals high.
5. Reset asserted during WAIT of a CPU read -> mem_en = 0 and no cpu_done during or after reset. The held request is re-issued from IDLE: mem_en at the cycle after the first post-reset edge.
6. Back-to-back CPU reads (0x0001 then 0x0002, memory returns 0xA1, 0xA2) with DMA idle -> mem_en cycles 5 apart; done pulses carry 0xA1 then 0xA2; the DONE-cycle request is not double-granted.
